eth_parser_ctrl: RTL and testbench
==================================

Name: eth_parser_ctrl

Overview:
Sequencer and result manager for the Ethernet header parser in the router port ingress path. It watches the 64-bit NetFPGA packet stream, drives the parser's word strobes (MAC_DA_HI, MAC_DASA, ETH_IP_VER), and throttles input so that no new destination MAC is latched while a MAC search is still running. It pairs each packet's end with its parser result and presents one in-order decision per packet to the output-port lookup stage, including packets too short to parse (runts).

Parameters:
DATA_WIDTH, 64, stream data width
CTRL_WIDTH, DATA_WIDTH/8, stream control width
NUM_QUEUES, 8, number of queues; the parser search takes NUM_QUEUES/2+1 cycles
NUM_QUEUES_WIDTH, log2(NUM_QUEUES), port number width
MAX_PKTS, 4, packets that may be outstanding between end-of-packet and decision consumption

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_data  in  DATA_WIDTH  stream data (observed only, not stored)
in_ctrl  in  CTRL_WIDTH  stream control; nonzero marks a header word or the last word
in_wr  in  1  word valid
in_rdy  out  1  word may be accepted; a transfer occurs when in_wr && in_rdy
word_MAC_DA_HI  out  1  to parser: current word is payload word 0
word_MAC_DASA  out  1  to parser: current word is payload word 1
word_ETH_IP_VER  out  1  to parser: current word is payload word 2
eth_parser_info_vld  in  1  parser result available
eth_parser_rd_info  out  1  pop parser result
is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast  in  1 each  parser result fields
mac_dst_port_num  in  NUM_QUEUES_WIDTH  parser result field
dec_vld  out  1  decision valid
dec_rdy  in  1  downstream accepts the decision
dec_for_us, dec_arp, dec_ip, dec_bcast, dec_runt  out  1 each  decision fields
dec_port  out  NUM_QUEUES_WIDTH  decision port

Behaviour:
- Reset (reset=0, asynchronous): all registered state is cleared; in_rdy=1, dec_vld=0, eth_parser_rd_info=0, all strobes 0, all dec_* outputs 0.
- Input FSM states:
  - HDR: words with in_ctrl!=0 are module headers and are ignored. The first accepted word with in_ctrl==0 is payload word 0; go to PAYLOAD with word_cnt=1.
  - PAYLOAD: word_cnt increments on each accepted word and saturates at 3.
  - An accepted word in PAYLOAD with in_ctrl!=0 is the last word. It still counts as a payload word and may itself be payload word 1 or 2. On the last word: push record {runt = (payload words < 3)} into the record FIFO, then return to HDR.
- Strobes are combinational and occur in the same cycle as the word they mark: word_MAC_DA_HI = xfer && state==HDR && in_ctrl==0; word_MAC_DASA = xfer && PAYLOAD && word_cnt==1; word_ETH_IP_VER = xfer && PAYLOAD && word_cnt==2. Here xfer = in_wr && in_rdy.
- Search guard: when word_ETH_IP_VER fires, guard is loaded with NUM_QUEUES/2+2 and then decrements to 0. While guard!=0 and the input FSM is in HDR with in_ctrl==0 presented, in_rdy=0. Header words are still accepted during the guard.
- Occupancy: in_rdy=0 whenever outstanding==MAX_PKTS. outstanding increments on a record push, decrements on a decision handshake, and does not change when both occur in the same cycle.
- Decision FSM states:
  - IDLE: when the record FIFO is not empty, pop the record. If runt, go to PRESENT with dec_runt=1 and all other dec_* fields 0. If not runt, go to WAIT.
  - WAIT: when eth_parser_info_vld=1, assert eth_parser_rd_info for exactly one cycle, register the parser fields into dec_*, and go to PRESENT.
  - PRESENT: dec_vld=1. Fields hold stable until dec_vld && dec_rdy, then return to IDLE.
- Throughput: at most one decision per 2 cycles. Decision order always equals packet order.
- Runt packets never assert word_ETH_IP_VER, so they never consume a parser result.
- Simultaneous record push and pop is legal. The FIFO cannot overflow because depth equals MAX_PKTS.
- Reset asserted mid-packet: the partial packet is discarded and the FSMs restart in HDR/IDLE. The parser FIFO is cleared by the same reset domain.
- Simulation-only check: error if eth_parser_info_vld=1 while the decision FSM is in IDLE with the record FIFO empty.

Decomposition:
- Shared defines include: stream widths, IN_HDR/IN_PAYLOAD and DEC_IDLE/DEC_WAIT/DEC_PRESENT encodings, and the SEARCH_GUARD = NUM_QUEUES/2+2 constant.
- One sub-module: the record FIFO is an instance of fallthrough_small_fifo (WIDTH 1, MAX_DEPTH_BITS log2(MAX_PKTS)).

Test Plan:
- Header word (ctrl=FF), then 8 payload words, the last with ctrl=01 → strobes fire on payload words 0, 1 and 2 exactly once each; one record is pushed with runt=0.
- Parser returns {for_us=1, arp=0, ip=1, bcast=0, port=2} four cycles after the last word → rd_info pulses for 1 cycle; dec_vld with dec_port=2, dec_ip=1.
- Two-word packet (last word ctrl=80) → no ETH_IP_VER strobe; dec_runt=1, rd_info stays 0.
- Back-to-back packets with the next packet's first word presented the cycle after the ETH_IP_VER word (NUM_QUEUES=8) → in_rdy=0 for 6 cycles, then the word is accepted.
- dec_rdy held 0 while 5 packets are sent → after 4 last words in_rdy=0; raising dec_rdy restores in_rdy and decisions emerge in order.
- Reset pulsed low mid-payload → all outputs return to reset values immediately; a following clean packet produces exactly one decision.

Source files
------------

// File: rtl/eth_parser_ctrl_pkg.sv
// Shared widths, state encodings and decision payload for the Ethernet parser sequencer.
package eth_parser_ctrl_pkg;

   localparam int unsigned DATA_WIDTH       = 64;
   localparam int unsigned CTRL_WIDTH       = DATA_WIDTH / 8;
   localparam int unsigned NUM_QUEUES       = 8;
   localparam int unsigned NUM_QUEUES_WIDTH = $clog2(NUM_QUEUES);
   localparam int unsigned MAX_PKTS         = 4;
   localparam int unsigned MAX_PKTS_BITS    = $clog2(MAX_PKTS);
   localparam int unsigned OCC_WIDTH        = $clog2(MAX_PKTS + 1);
   localparam int unsigned SEARCH_GUARD     = NUM_QUEUES / 2 + 2;
   localparam int unsigned GUARD_WIDTH      = $clog2(SEARCH_GUARD + 1);

   typedef enum logic {
      IN_HDR     = 1'b0,
      IN_PAYLOAD = 1'b1
   } in_state_t;

   typedef enum logic [1:0] {
      DEC_IDLE    = 2'd0,
      DEC_WAIT    = 2'd1,
      DEC_PRESENT = 2'd2
   } dec_state_t;

   typedef struct packed {
      logic                        for_us;
      logic                        arp;
      logic                        ip;
      logic                        bcast;
      logic                        runt;
      logic [NUM_QUEUES_WIDTH-1:0] port;
   } dec_info_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO; dout shows the head entry whenever not empty.
module fallthrough_small_fifo #(
   parameter int unsigned WIDTH          = 1,
   parameter int unsigned MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
   localparam int unsigned PW    = MAX_DEPTH_BITS + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer bit distinguishes full from empty
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign dout  = mem[rd_ptr[PW-2:0]];
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[PW-2:0]] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      end
   end

endmodule

// File: rtl/eth_parser_ctrl.sv
// Sequences Ethernet parser word strobes, throttles input during MAC search and
// pairs each packet end with its parser result into one in-order decision.
module eth_parser_ctrl
   import eth_parser_ctrl_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_WIDTH-1:0]       in_data,
   input  logic [CTRL_WIDTH-1:0]       in_ctrl,
   input  logic                        in_wr,
   output logic                        in_rdy,
   output logic                        word_MAC_DA_HI,
   output logic                        word_MAC_DASA,
   output logic                        word_ETH_IP_VER,
   input  logic                        eth_parser_info_vld,
   output logic                        eth_parser_rd_info,
   input  logic                        is_for_us,
   input  logic                        is_arp_pkt,
   input  logic                        is_ip_pkt,
   input  logic                        is_broadcast,
   input  logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num,
   output logic                        dec_vld,
   input  logic                        dec_rdy,
   output logic                        dec_for_us,
   output logic                        dec_arp,
   output logic                        dec_ip,
   output logic                        dec_bcast,
   output logic                        dec_runt,
   output logic [NUM_QUEUES_WIDTH-1:0] dec_port
);

   in_state_t              in_state;
   in_state_t              in_state_nxt;
   dec_state_t             dec_state;
   dec_state_t             dec_state_nxt;
   dec_info_t              dec_q;
   dec_info_t              dec_nxt;
   logic [1:0]             word_cnt;
   logic [GUARD_WIDTH-1:0] guard;
   logic [OCC_WIDTH-1:0]   outstanding;
   logic                   hdr_ctrl;
   logic                   xfer;
   logic                   rec_push;
   logic                   rec_pop;
   logic                   rec_runt;
   logic                   rec_dout;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   dec_hs;
   logic                   unused_ok;

   // Stream data is only observed by the parser itself
   assign unused_ok = ^{in_data, fifo_full};

   assign hdr_ctrl = (in_ctrl != '0);
   assign in_rdy   = (outstanding != OCC_WIDTH'(MAX_PKTS)) &&
                     !((guard != '0) && (in_state == IN_HDR) && !hdr_ctrl);
   assign xfer     = in_wr && in_rdy;
   assign dec_hs   = dec_vld && dec_rdy;

   assign word_MAC_DA_HI  = xfer && (in_state == IN_HDR) && !hdr_ctrl;
   assign word_MAC_DASA   = xfer && (in_state == IN_PAYLOAD) && (word_cnt == 2'd1);
   assign word_ETH_IP_VER = xfer && (in_state == IN_PAYLOAD) && (word_cnt == 2'd2);
   assign rec_push        = xfer && (in_state == IN_PAYLOAD) && hdr_ctrl;
   // Last word counts as a payload word: fewer than 3 means word_cnt was still 1
   assign rec_runt        = (word_cnt < 2'd2);

   assign dec_for_us = dec_q.for_us;
   assign dec_arp    = dec_q.arp;
   assign dec_ip     = dec_q.ip;
   assign dec_bcast  = dec_q.bcast;
   assign dec_runt   = dec_q.runt;
   assign dec_port   = dec_q.port;

   fallthrough_small_fifo #(
      .WIDTH          (1),
      .MAX_DEPTH_BITS (MAX_PKTS_BITS)
   ) u_rec_fifo (
      .clk   (clk),
      .reset (reset),
      .din   (rec_runt),
      .wr_en (rec_push),
      .rd_en (rec_pop),
      .dout  (rec_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_state  <= IN_HDR;
         dec_state <= DEC_IDLE;
         dec_vld   <= 1'b0;
         dec_q     <= '0;
      end else begin
         in_state  <= in_state_nxt;
         dec_state <= dec_state_nxt;
         dec_vld   <= (dec_state_nxt == DEC_PRESENT);
         dec_q     <= dec_nxt;
      end
   end

   always_comb begin
      in_state_nxt = in_state;
      case (in_state)
         IN_HDR:     if (word_MAC_DA_HI) in_state_nxt = IN_PAYLOAD;
         IN_PAYLOAD: if (rec_push)       in_state_nxt = IN_HDR;
         default:                        in_state_nxt = IN_HDR;
      endcase
   end

   // Decision sequencing: pop record, fetch parser result if needed, present
   always_comb begin
      dec_state_nxt      = dec_state;
      dec_nxt            = dec_q;
      rec_pop            = 1'b0;
      eth_parser_rd_info = 1'b0;
      case (dec_state)
         DEC_IDLE: begin
            if (!fifo_empty) begin
               rec_pop = 1'b1;
               if (rec_dout) begin
                  dec_nxt       = '0;
                  dec_nxt.runt  = 1'b1;
                  dec_state_nxt = DEC_PRESENT;
               end else begin
                  dec_state_nxt = DEC_WAIT;
               end
            end
         end
         DEC_WAIT: begin
            if (eth_parser_info_vld) begin
               eth_parser_rd_info = 1'b1;
               dec_nxt.for_us     = is_for_us;
               dec_nxt.arp        = is_arp_pkt;
               dec_nxt.ip         = is_ip_pkt;
               dec_nxt.bcast      = is_broadcast;
               dec_nxt.runt       = 1'b0;
               dec_nxt.port       = mac_dst_port_num;
               dec_state_nxt      = DEC_PRESENT;
            end
         end
         DEC_PRESENT: if (dec_rdy) dec_state_nxt = DEC_IDLE;
         default:     dec_state_nxt = DEC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_cnt    <= '0;
         guard       <= '0;
         outstanding <= '0;
      end else begin
         if (word_MAC_DA_HI)
            word_cnt <= 2'd1;
         else if (xfer && (in_state == IN_PAYLOAD) && (word_cnt != 2'd3))
            word_cnt <= word_cnt + 2'd1;

         if (word_ETH_IP_VER)
            guard <= GUARD_WIDTH'(SEARCH_GUARD);
         else if (guard != '0)
            guard <= guard - GUARD_WIDTH'(1);

         if (rec_push && !dec_hs)
            outstanding <= outstanding + OCC_WIDTH'(1);
         else if (dec_hs && !rec_push)
            outstanding <= outstanding - OCC_WIDTH'(1);
      end
   end

   // A parser result with no packet waiting for it means strobes and records diverged
   a_no_orphan_info: assert property (@(posedge clk) disable iff (!reset)
      !(eth_parser_info_vld && (dec_state == DEC_IDLE) && fifo_empty))
      else $error("eth_parser_info_vld with no pending packet record");

endmodule

// File: tb/tb_eth_parser_ctrl.sv
// Randomized packet-level bench for eth_parser_ctrl with a queue-based reference model.
module tb_eth_parser_ctrl;

   localparam int GUARD_CYC  = 8 / 2 + 2;
   localparam int SEARCH_CYC = 8 / 2 + 1;
   localparam int MAXP       = 4;

   typedef struct packed {
      logic       for_us;
      logic       arp;
      logic       ip;
      logic       bcast;
      logic       runt;
      logic [2:0] port;
   } exp_dec_t;

   typedef struct {
      logic [7:0] ctrl;
      int         pidx;
      bit         last;
      exp_dec_t   d;
   } word_t;

   typedef struct {
      exp_dec_t d;
      longint   search_done;
      longint   rdy_cyc;
   } pres_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_wr;
   logic        in_rdy;
   logic        word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER;
   logic        eth_parser_info_vld, eth_parser_rd_info;
   logic        is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast;
   logic [2:0]  mac_dst_port_num;
   logic        dec_vld, dec_rdy;
   logic        dec_for_us, dec_arp, dec_ip, dec_bcast, dec_runt;
   logic [2:0]  dec_port;

   eth_parser_ctrl dut (
      .clk                 (clk),
      .reset               (reset),
      .in_data             (in_data),
      .in_ctrl             (in_ctrl),
      .in_wr               (in_wr),
      .in_rdy              (in_rdy),
      .word_MAC_DA_HI      (word_MAC_DA_HI),
      .word_MAC_DASA       (word_MAC_DASA),
      .word_ETH_IP_VER     (word_ETH_IP_VER),
      .eth_parser_info_vld (eth_parser_info_vld),
      .eth_parser_rd_info  (eth_parser_rd_info),
      .is_for_us           (is_for_us),
      .is_arp_pkt          (is_arp_pkt),
      .is_ip_pkt           (is_ip_pkt),
      .is_broadcast        (is_broadcast),
      .mac_dst_port_num    (mac_dst_port_num),
      .dec_vld             (dec_vld),
      .dec_rdy             (dec_rdy),
      .dec_for_us          (dec_for_us),
      .dec_arp             (dec_arp),
      .dec_ip              (dec_ip),
      .dec_bcast           (dec_bcast),
      .dec_runt            (dec_runt),
      .dec_port            (dec_port)
   );

   always #5 clk = ~clk;

   int       n_tests, n_fail;
   word_t    wq[$];
   pres_t    pq[$];
   exp_dec_t eq[$];
   longint   cyc, last_ipver;
   int       out_cnt, wr_pct, rdy_pct, lag_lo, lag_hi;
   int       stall_cnt, lasts_acc, n_dec, n_rd, n_nonrunt, n_da, n_dasa, n_ipv;
   bit       rd_prev;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_counts();
      stall_cnt = 0; lasts_acc = 0; n_dec = 0; n_rd = 0; n_nonrunt = 0;
      n_da = 0; n_dasa = 0; n_ipv = 0;
   endtask

   task automatic model_reset();
      wq.delete(); pq.delete(); eq.delete();
      out_cnt = 0; last_ipver = -100; rd_prev = 1'b0;
      clear_counts();
   endtask

   task automatic add_pkt(input int h, input int n, input exp_dec_t dfix, input bit use_fix);
      exp_dec_t d;
      word_t    w;
      d = use_fix ? dfix : exp_dec_t'(8'($urandom));
      d.runt = 1'b0;
      if (n < 3) begin
         d = '0;
         d.runt = 1'b1;
      end else begin
         n_nonrunt++;
      end
      for (int i = 0; i < h; i++) begin
         w.ctrl = 8'($urandom_range(1, 255)); w.pidx = -1; w.last = 1'b0; w.d = d;
         wq.push_back(w);
      end
      for (int p = 0; p < n; p++) begin
         w.ctrl = (p == n - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
         w.pidx = p; w.last = (p == n - 1); w.d = d;
         wq.push_back(w);
      end
   endtask

   task automatic drive_idle();
      in_wr = 1'b0; in_ctrl = 8'h00; in_data = '0; dec_rdy = 1'b0;
      eth_parser_info_vld = 1'b0; is_for_us = 1'b0; is_arp_pkt = 1'b0;
      is_ip_pkt = 1'b0; is_broadcast = 1'b0; mac_dst_port_num = '0;
   endtask

   // One clock: drive after the edge, check and advance the model at the falling edge
   task automatic step();
      word_t    w;
      pres_t    p;
      exp_dec_t got;
      bit       xfer, exp_rdy, guard_on, hs, lw;
      int       pi;
      longint   lag;
      @(posedge clk); #1;
      cyc++;
      in_wr = 1'b0; in_ctrl = 8'h00;
      if (wq.size() > 0 && $urandom_range(0, 99) < wr_pct) begin
         in_wr = 1'b1; in_ctrl = wq[0].ctrl;
      end
      in_data = {$urandom, $urandom};
      dec_rdy = ($urandom_range(0, 99) < rdy_pct);
      eth_parser_info_vld = 1'b0;
      {is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast, mac_dst_port_num} = '0;
      if (pq.size() > 0 && pq[0].rdy_cyc != 0 && pq[0].rdy_cyc <= cyc) begin
         eth_parser_info_vld = 1'b1;
         is_for_us = pq[0].d.for_us; is_arp_pkt = pq[0].d.arp;
         is_ip_pkt = pq[0].d.ip; is_broadcast = pq[0].d.bcast;
         mac_dst_port_num = pq[0].d.port;
      end
      @(negedge clk);

      if (in_wr) begin
         guard_on = (wq[0].pidx == 0) && (cyc - last_ipver >= 1) && (cyc - last_ipver <= GUARD_CYC);
         exp_rdy  = (out_cnt < MAXP) && !guard_on;
         check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
         if (!in_rdy && wq[0].pidx == 0) stall_cnt++;
      end
      xfer = in_wr && in_rdy;
      pi = -1; lw = 1'b0;
      if (xfer) begin
         w = wq.pop_front(); pi = w.pidx; lw = w.last;
      end
      check("strb_da_hi", 32'(word_MAC_DA_HI), 32'(pi == 0));
      check("strb_dasa", 32'(word_MAC_DASA), 32'(pi == 1));
      check("strb_ip_ver", 32'(word_ETH_IP_VER), 32'(pi == 2));
      n_da += int'(word_MAC_DA_HI); n_dasa += int'(word_MAC_DASA); n_ipv += int'(word_ETH_IP_VER);

      if (pi == 2) begin
         last_ipver = cyc;
         p.d = w.d; p.search_done = cyc + SEARCH_CYC; p.rdy_cyc = 0;
         pq.push_back(p);
      end
      if (lw) begin
         lasts_acc++;
         eq.push_back(w.d);
         if (!w.d.runt && pq.size() > 0) begin
            p = pq.pop_back();
            lag = cyc + 1 + longint'($urandom_range(lag_lo, lag_hi));
            p.rdy_cyc = (lag > p.search_done) ? lag : p.search_done;
            pq.push_back(p);
         end
      end

      hs = dec_vld && dec_rdy;
      if (dec_vld && eq.size() == 0) check("dec_spurious", 32'(dec_vld), 32'(0));
      if (hs && eq.size() > 0) begin
         got = {dec_for_us, dec_arp, dec_ip, dec_bcast, dec_runt, dec_port};
         check("dec_fields", 32'(got), 32'(eq.pop_front()));
         n_dec++;
      end

      if (eth_parser_rd_info) begin
         check("rd_info_vld", 32'(eth_parser_info_vld), 32'(1));
         check("rd_info_pulse", 32'(rd_prev), 32'(0));
         n_rd++;
         if (pq.size() > 0) pq.delete(0);
      end
      rd_prev = eth_parser_rd_info;
      out_cnt += int'(lw) - int'(hs);
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      while ((wq.size() > 0 || eq.size() > 0) && k < limit) begin
         step();
         k++;
      end
      check("drain_left", 32'(wq.size() + eq.size()), 32'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_rdy"}, 32'(in_rdy), 32'(1));
      check({tag, "_dec_vld"}, 32'(dec_vld), 32'(0));
      check({tag, "_rd_info"}, 32'(eth_parser_rd_info), 32'(0));
      check({tag, "_strobes"}, 32'({word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER}), 32'(0));
      check({tag, "_dec_fields"},
            32'({dec_for_us, dec_arp, dec_ip, dec_bcast, dec_runt, dec_port}), 32'(0));
   endtask

   initial begin
      exp_dec_t d_fix;
      n_tests = 0; n_fail = 0; cyc = 0;
      wr_pct = 100; rdy_pct = 100; lag_lo = 3; lag_hi = 3;
      drive_idle();
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;

      // Long packet with a fixed parser answer four cycles after its last word
      clear_counts();
      d_fix = '0;
      d_fix.for_us = 1'b1; d_fix.ip = 1'b1; d_fix.port = 3'd2;
      add_pkt(1, 8, d_fix, 1'b1);
      drain(200);
      check("long_da_cnt", 32'(n_da), 32'(1));
      check("long_dasa_cnt", 32'(n_dasa), 32'(1));
      check("long_ipv_cnt", 32'(n_ipv), 32'(1));
      check("long_rd_cnt", 32'(n_rd), 32'(1));
      check("long_dec_cnt", 32'(n_dec), 32'(1));

      // Two-word runt
      clear_counts();
      add_pkt(0, 2, d_fix, 1'b0);
      drain(200);
      check("runt_ipv_cnt", 32'(n_ipv), 32'(0));
      check("runt_rd_cnt", 32'(n_rd), 32'(0));
      check("runt_dec_cnt", 32'(n_dec), 32'(1));

      // Back-to-back: second first-word lands right after the search starts
      clear_counts();
      add_pkt(0, 3, d_fix, 1'b0);
      add_pkt(0, 3, d_fix, 1'b0);
      drain(200);
      check("guard_stalls", 32'(stall_cnt), 32'(GUARD_CYC));
      check("guard_dec_cnt", 32'(n_dec), 32'(2));

      // Occupancy limit with decisions held
      clear_counts();
      rdy_pct = 0;
      for (int i = 0; i < 5; i++) add_pkt(1, int'($urandom_range(3, 5)), d_fix, 1'b0);
      repeat (100) step();
      check("occ_lasts", 32'(lasts_acc), 32'(4));
      check("occ_in_rdy", 32'(in_rdy), 32'(0));
      check("occ_dec_cnt", 32'(n_dec), 32'(0));
      rdy_pct = 100;
      drain(300);
      check("occ_dec_after", 32'(n_dec), 32'(5));

      // Reset in the middle of a payload
      clear_counts();
      add_pkt(0, 8, d_fix, 1'b0);
      repeat (4) step();
      drive_idle();
      #1 reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      add_pkt(1, 5, d_fix, 1'b0);
      drain(200);
      check("midrst_dec_cnt", 32'(n_dec), 32'(1));
      check("midrst_rd_cnt", 32'(n_rd), 32'(1));

      // Random traffic with random backpressure and parser latency
      clear_counts();
      wr_pct = 70; rdy_pct = 60; lag_lo = 0; lag_hi = 4;
      for (int i = 0; i < 30; i++)
         add_pkt(int'($urandom_range(0, 2)), int'($urandom_range(2, 9)), d_fix, 1'b0);
      drain(4000);
      check("rand_dec_cnt", 32'(n_dec), 32'(30));
      check("rand_rd_cnt", 32'(n_rd), 32'(n_nonrunt));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
